// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Debounces and classifies active-low push-buttons. Each key
//                gets a 2-flop synchronizer and its own FSM. The FSM produces
//                single-cycle press, long-press, auto-repeat and release
//                events plus a debounced level. A single shared prescaler
//                generates a 1 ms tick that paces every key timer.
//  Ports       : clk         - system clock, CLK_FRE Hz
//                rst         - synchronous active-high reset
//                key         - raw pins, active-low, asynchronous to clk
//                key_press   - 1-cycle pulse on debounced press
//                key_long    - 1-cycle pulse LONG_MS after key_press
//                key_repeat  - 1-cycle pulse every REP_MS after key_long
//                key_release - 1-cycle pulse on debounced release
//                key_level   - debounced state, 1 = held
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int CLK_FRE = 50_000_000,
    parameter int KEY_NUM = 3,
    parameter int DEB_MS  = 20,
    parameter int LONG_MS = 1000,
    parameter int REP_MS  = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_level
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PRE_MAX = CLK_FRE / 1000 - 1;
    localparam int c_PRE_W   = (c_PRE_MAX > 0) ? $clog2(c_PRE_MAX + 1) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_TC = c_PRE_W'(c_PRE_MAX);

    localparam logic [15:0] c_DEB_TC  = 16'(DEB_MS - 1);
    localparam logic [15:0] c_LONG_TC = 16'(LONG_MS - 1);
    localparam logic [15:0] c_REP_TC  = 16'(REP_MS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_DN_CHK = 3'd1;
    localparam logic [2:0] c_S_HELD   = 3'd2;
    localparam logic [2:0] c_S_REPEAT = 3'd3;
    localparam logic [2:0] c_S_UP_CHK = 3'd4;

    // ------------------------------------------------------------------
    // Synchronizer: inverts the pins so that 1 means pressed.
    // ------------------------------------------------------------------
    logic [KEY_NUM-1:0] r_sync1;
    logic [KEY_NUM-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~key;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Shared 1 ms prescaler. With CLK_FRE = 1000 the counter is pinned at
    // its terminal count of 0, so the tick is asserted every cycle.
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;

    assign w_tick = (r_pre == c_PRE_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-key classifier FSM
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
        logic [2:0]  r_state;
        logic [2:0]  w_state_nxt;
        logic [15:0] r_cnt;
        logic [15:0] w_cnt_nxt;
        // Return target for a bounce seen during release debounce:
        // 0 = HELD, 1 = REPEAT.
        logic        r_ret;
        logic        w_ret_nxt;
        logic        r_press;
        logic        r_long;
        logic        r_rep;
        logic        r_rel;
        logic        r_level;
        logic        w_press_nxt;
        logic        w_long_nxt;
        logic        w_rep_nxt;
        logic        w_rel_nxt;
        logic        w_level_nxt;
        logic        w_ks;

        assign w_ks = r_sync2[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_S_IDLE;
                r_cnt   <= '0;
                r_ret   <= 1'b0;
                r_press <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
                r_rel   <= 1'b0;
                r_level <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_ret   <= w_ret_nxt;
                r_press <= w_press_nxt;
                r_long  <= w_long_nxt;
                r_rep   <= w_rep_nxt;
                r_rel   <= w_rel_nxt;
                r_level <= w_level_nxt;
            end
        end

        // A change on the synchronized key is always tested before the
        // tick, so a key edge arriving on a final tick suppresses the event.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_ret_nxt   = r_ret;
            w_press_nxt = 1'b0;
            w_long_nxt  = 1'b0;
            w_rep_nxt   = 1'b0;
            w_rel_nxt   = 1'b0;
            w_level_nxt = r_level;

            case (r_state)
                c_S_IDLE: begin
                    if (w_ks) begin
                        w_state_nxt = c_S_DN_CHK;
                        w_cnt_nxt   = '0;
                    end
                end
                c_S_DN_CHK: begin
                    if (!w_ks) begin
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_DEB_TC) begin
                            w_state_nxt = c_S_HELD;
                            w_press_nxt = 1'b1;
                            w_level_nxt = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 16'd1;
                        end
                    end
                end
                c_S_HELD: begin
                    if (!w_ks) begin
                        w_state_nxt = c_S_UP_CHK;
                        w_ret_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_LONG_TC) begin
                            w_state_nxt = c_S_REPEAT;
                            w_long_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 16'd1;
                        end
                    end
                end
                c_S_REPEAT: begin
                    if (!w_ks) begin
                        w_state_nxt = c_S_UP_CHK;
                        w_ret_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_REP_TC) begin
                            w_rep_nxt = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 16'd1;
                        end
                    end
                end
                c_S_UP_CHK: begin
                    // key_level stays high here; only a completed release
                    // debounce clears it.
                    if (w_ks) begin
                        w_state_nxt = r_ret ? c_S_REPEAT : c_S_HELD;
                        w_cnt_nxt   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_DEB_TC) begin
                            w_state_nxt = c_S_IDLE;
                            w_rel_nxt   = 1'b1;
                            w_level_nxt = 1'b0;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        assign key_press[gi]   = r_press;
        assign key_long[gi]    = r_long;
        assign key_repeat[gi]  = r_rep;
        assign key_release[gi] = r_rel;
        assign key_level[gi]   = r_level;
    end

endmodule
`default_nettype wire
